pwm_phased: RTL

PWM_PHASED -- requirements
Module: pwm_phased

---
 rtl/pwm_pkg.sv | 16 +
 rtl/pwm_channel.sv | 98 +++++++++
 rtl/pwm_phased.sv | 99 +++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the phased PWM block.
//   wr_field_e   - selects which shadow register a write strobe targets
//   CTRL_*_BIT   - bit positions inside wr_data for a CTRL write
package pwm_pkg;

    typedef enum logic [1:0] {
        FIELD_RISE   = 2'd0,
        FIELD_FALL   = 2'd1,
        FIELD_PERIOD = 2'd2,
        FIELD_CTRL   = 2'd3
    } wr_field_e;

    localparam int unsigned CTRL_EN_BIT  = 0;
    localparam int unsigned CTRL_INV_BIT = 1;

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM output with shadow/active rise, fall and control registers.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   i_cnt         - shared period counter
//   i_wr_en       - write strobe already qualified with this channel's select
//   i_wr_field    - target field (RISE/FALL/CTRL; PERIOD is ignored here)
//   i_wr_data     - write data
//   i_load        - shadow-to-active transfer at the period wrap
//   o_pwm         - channel output, (st & enable) ^ invert from flops only
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int unsigned PWM_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PWM_WIDTH-1:0] i_cnt,
    input  logic                 i_wr_en,
    input  logic [1:0]           i_wr_field,
    input  logic [PWM_WIDTH-1:0] i_wr_data,
    input  logic                 i_load,
    output logic                 o_pwm
);

    logic [PWM_WIDTH-1:0] r_rise_sh;
    logic [PWM_WIDTH-1:0] r_fall_sh;
    logic                 r_en_sh;
    logic                 r_inv_sh;
    logic [PWM_WIDTH-1:0] r_rise;
    logic [PWM_WIDTH-1:0] r_fall;
    logic                 r_en;
    logic                 r_inv;
    logic                 r_st;

    logic w_rise_hit;
    logic w_fall_hit;
    logic w_st_d;

    // Equality via XOR-reduce keeps the datapath free of magnitude comparators.
    assign w_rise_hit = ~|(i_cnt ^ r_rise);
    assign w_fall_hit = ~|(i_cnt ^ r_fall);

    // Clear dominates set, so rise == fall produces a constant low output.
    always_comb begin
        w_st_d = r_st;
        if (!r_en || w_fall_hit) begin
            w_st_d = 1'b0;
        end else if (w_rise_hit) begin
            w_st_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rise_sh <= '0;
            r_fall_sh <= '0;
            r_en_sh   <= 1'b0;
            r_inv_sh  <= 1'b0;
        end else if (i_wr_en) begin
            if (i_wr_field == FIELD_RISE) begin
                r_rise_sh <= i_wr_data;
            end
            if (i_wr_field == FIELD_FALL) begin
                r_fall_sh <= i_wr_data;
            end
            if (i_wr_field == FIELD_CTRL) begin
                r_en_sh  <= i_wr_data[CTRL_EN_BIT];
                r_inv_sh <= i_wr_data[CTRL_INV_BIT];
            end
        end
    end

    // Transfer reads the shadow values from before any same-edge write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rise <= '0;
            r_fall <= '0;
            r_en   <= 1'b0;
            r_inv  <= 1'b0;
        end else if (i_load) begin
            r_rise <= r_rise_sh;
            r_fall <= r_fall_sh;
            r_en   <= r_en_sh;
            r_inv  <= r_inv_sh;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st <= 1'b0;
        end else begin
            r_st <= w_st_d;
        end
    end

    assign o_pwm = (r_st & r_en) ^ r_inv;

endmodule

// File: rtl/pwm_phased.sv
// pwm_phased: multi-channel PWM sharing one period counter, with shadow
// registers that transfer atomically to the active set at a period wrap.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   wr_data         - write data for the selected shadow register
//   wr_sel          - target channel (ignored for PERIOD)
//   wr_field        - 0=RISE 1=FALL 2=PERIOD 3=CTRL
//   wr_en           - single-cycle write strobe
//   commit          - request shadow-to-active transfer at the next wrap
//   pwm_out         - channel outputs
//   period_tick     - one-cycle pulse in the cycle the counter is 0 after a wrap
//   update_pending  - committed update waiting for the wrap
module pwm_phased
    import pwm_pkg::*;
#(
    parameter  int unsigned PWM_WIDTH = 16,
    parameter  int unsigned NUM_PWM   = 4,
    localparam int unsigned SEL_W     = (NUM_PWM > 1) ? $clog2(NUM_PWM) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PWM_WIDTH-1:0] wr_data,
    input  logic [SEL_W-1:0]     wr_sel,
    input  logic [1:0]           wr_field,
    input  logic                 wr_en,
    input  logic                 commit,
    output logic [NUM_PWM-1:0]   pwm_out,
    output logic                 period_tick,
    output logic                 update_pending
);

    logic [PWM_WIDTH-1:0] r_cnt;
    logic [PWM_WIDTH-1:0] r_period;
    logic [PWM_WIDTH-1:0] r_period_sh;
    logic                 r_pending;
    logic                 r_tick;

    logic                 w_wrap;
    logic                 w_load;
    logic                 w_pending_d;

    assign w_wrap = ~|(r_cnt ^ r_period);
    assign w_load = w_wrap & r_pending;

    // A commit landing on the transfer edge is absorbed (pending clears);
    // one landing on a wrap with nothing pending waits for the next wrap.
    always_comb begin
        w_pending_d = r_pending;
        if (w_load) begin
            w_pending_d = 1'b0;
        end else if (commit) begin
            w_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_period    <= '1;
            r_period_sh <= '1;
            r_pending   <= 1'b0;
            r_tick      <= 1'b0;
        end else begin
            r_cnt     <= w_wrap ? '0 : r_cnt + PWM_WIDTH'(1);
            r_tick    <= w_wrap;
            r_pending <= w_pending_d;
            if (w_load) begin
                r_period <= r_period_sh;
            end
            if (wr_en && (wr_field == FIELD_PERIOD)) begin
                r_period_sh <= wr_data;
            end
        end
    end

    for (genvar i = 0; i < NUM_PWM; i++) begin : g_ch
        logic w_ch_we;

        // Selects with no matching channel fall through and write nothing.
        assign w_ch_we = wr_en & ~|(wr_sel ^ SEL_W'(i));

        pwm_channel #(
            .PWM_WIDTH (PWM_WIDTH)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_cnt      (r_cnt),
            .i_wr_en    (w_ch_we),
            .i_wr_field (wr_field),
            .i_wr_data  (wr_data),
            .i_load     (w_load),
            .o_pwm      (pwm_out[i])
        );
    end

    assign period_tick    = r_tick;
    assign update_pending = r_pending;

endmodule
